// File: rtl/operand_bypass.sv
// Source-operand bypass network with retired-write history and load-use stall FSM.
// Optional BYPASS_STATS_EN adds forward/stall cycle counters (stat_fwd, stat_stall).
module operand_bypass #(
  parameter int XLEN       = 64,
  parameter int HIST_DEPTH = 2,
  parameter int LOAD_LAT   = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [XLEN-1:0] rf_rs1,
  input  logic [XLEN-1:0] rf_rs2,
  input  logic            ex_valid,
  input  logic            ex_is_load,
  input  logic [4:0]      ex_dst,
  input  logic [XLEN-1:0] ex_data,
  input  logic            mem_valid,
  input  logic [4:0]      mem_dst,
  input  logic [XLEN-1:0] mem_data,
  input  logic            mem_busy,
  input  logic            wb_valid,
  input  logic [4:0]      wb_dst,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic            stall
`ifdef BYPASS_STATS_EN
  ,
  output logic [31:0]     stat_fwd,
  output logic [31:0]     stat_stall
`endif
);

  localparam logic       IDLE   = 1'b0;
  localparam logic       STALL  = 1'b1;
  localparam logic [1:0] LAT_M1 = 2'(LOAD_LAT - 1);

  logic            hist_vld_r  [HIST_DEPTH];
  logic [4:0]      hist_dst_r  [HIST_DEPTH];
  logic [XLEN-1:0] hist_data_r [HIST_DEPTH];

  logic [4:0]      src_s [2];
  logic [XLEN-1:0] rf_s  [2];
  logic [XLEN-1:0] opv_s [2];
  logic            hit_s [2];
  logic [XLEN-1:0] hv_s  [2];
  logic            hh_s  [2];

  logic       state_r, state_nx_s;
  logic [1:0] cnt_r, cnt_nx_s;
  logic       hz_s, stall_s;

  assign src_s[0] = rs1;
  assign src_s[1] = rs2;
  assign rf_s[0]  = rf_rs1;
  assign rf_s[1]  = rf_rs2;

  // Per-source operand select; history scanned oldest to newest so slot 0 wins.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      hh_s[s] = 1'b0;
      hv_s[s] = {XLEN{1'b0}};
      for (int h = HIST_DEPTH - 1; h >= 0; h--) begin
        hh_s[s] = hh_s[s] | (hist_vld_r[h] & (hist_dst_r[h] == src_s[s]));
        hv_s[s] = (hist_vld_r[h] && (hist_dst_r[h] == src_s[s])) ? hist_data_r[h] : hv_s[s];
      end
      if (src_s[s] == 5'd0) begin
        opv_s[s] = {XLEN{1'b0}};
        hit_s[s] = 1'b0;
      end else if (ex_valid && !ex_is_load && (ex_dst == src_s[s])) begin
        opv_s[s] = ex_data;
        hit_s[s] = 1'b1;
      end else if (mem_valid && (mem_dst == src_s[s])) begin
        opv_s[s] = mem_data;
        hit_s[s] = 1'b1;
      end else if (wb_valid && (wb_dst == src_s[s])) begin
        opv_s[s] = wb_data;
        hit_s[s] = 1'b1;
      end else if (hh_s[s]) begin
        opv_s[s] = hv_s[s];
        hit_s[s] = 1'b1;
      end else begin
        opv_s[s] = rf_s[s];
        hit_s[s] = 1'b0;
      end
    end
  end

  assign hz_s = ex_valid & ex_is_load & (ex_dst != 5'd0) & ((ex_dst == rs1) | (ex_dst == rs2));

  // Load-use stall FSM next state; flush overrides everything.
  always_comb begin
    stall_s    = 1'b0;
    state_nx_s = IDLE;
    cnt_nx_s   = 2'd0;
    if (flush) begin
      stall_s    = 1'b0;
      state_nx_s = IDLE;
      cnt_nx_s   = 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          stall_s = hz_s;
          if (hz_s) begin
            state_nx_s = STALL;
            cnt_nx_s   = LAT_M1;
          end else begin
            state_nx_s = IDLE;
            cnt_nx_s   = 2'd0;
          end
        end
        STALL: begin
          stall_s  = (cnt_r != 2'd0) | mem_busy;
          cnt_nx_s = (cnt_r != 2'd0) ? (cnt_r - 2'd1) : 2'd0;
          if ((cnt_r == 2'd0) && !mem_busy) begin
            state_nx_s = IDLE;
          end else begin
            state_nx_s = STALL;
          end
        end
        default: begin
          stall_s    = 1'b0;
          state_nx_s = IDLE;
          cnt_nx_s   = 2'd0;
        end
      endcase
    end
  end

  // Outputs forced quiet while reset is held.
  always_comb begin
    if (!reset) begin
      op1   = {XLEN{1'b0}};
      op2   = {XLEN{1'b0}};
      stall = 1'b0;
    end else begin
      op1   = opv_s[0];
      op2   = opv_s[1];
      stall = stall_s;
    end
  end

  // FSM state and counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= 2'd0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Retired-write history shift register; flush leaves committed writes intact.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int h = 0; h < HIST_DEPTH; h++) begin
        hist_vld_r[h]  <= 1'b0;
        hist_dst_r[h]  <= 5'd0;
        hist_data_r[h] <= {XLEN{1'b0}};
      end
    end else if (wb_valid && (wb_dst != 5'd0)) begin
      for (int h = HIST_DEPTH - 1; h > 0; h--) begin
        hist_vld_r[h]  <= hist_vld_r[h-1];
        hist_dst_r[h]  <= hist_dst_r[h-1];
        hist_data_r[h] <= hist_data_r[h-1];
      end
      hist_vld_r[0]  <= 1'b1;
      hist_dst_r[0]  <= wb_dst;
      hist_data_r[0] <= wb_data;
    end
  end

`ifdef BYPASS_STATS_EN
  // Free-running, wrapping usage counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_fwd   <= 32'd0;
      stat_stall <= 32'd0;
    end else begin
      if ((hit_s[0] | hit_s[1]) && !stall_s) begin
        stat_fwd <= stat_fwd + 32'd1;
      end
      if (stall_s) begin
        stat_stall <= stat_stall + 32'd1;
      end
    end
  end
`endif

endmodule
